rtc_bcd_core: RTL and testbench

- Parametrised successor to the fixed hh:mm:ss counter chain.
- One block holds the time-of-day in BCD, with:
  - per-digit up/down adjust;
  - a 12/24-hour display mode;
  - a pause control;
  - an hh:mm alarm with ring timeout and snooze.
- Sits between freq_div (S_F tick) and the pb_ve debouncers / seg_disp; ADJ_SEL is driven directly from the display pointer.

---
 rtl/rtc_pkg.sv | 69 ++++++
 rtl/rtc_alarm_fsm.sv | 104 ++++++++++
 rtl/rtc_bcd_core.sv | 203 ++++++++++++++++++++
 tb/tb_rtc_bcd_core.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the BCD real-time clock: digit limits, alarm states,
// and BCD helpers (wrap-within-range digit step, 24h <-> 12h hour conversion).
// No ports; imported by rtc_bcd_core and rtc_alarm_fsm.
package rtc_pkg;

  // Legal digit ranges of the internal 24-hour BCD time
  localparam logic [3:0] UNITS_MAX     = 4'd9;  // any units digit
  localparam logic [3:0] MS_TENS_MAX   = 4'd5;  // minute/second tens
  localparam logic [3:0] HR_TENS_MAX   = 4'd2;  // hour tens
  localparam logic [3:0] HR_UNITS_MAX2 = 4'd3;  // hour units while hour tens is 2
  localparam logic [4:0] HR_BIN_MAX    = 5'd23;

  localparam int unsigned RING_CNT_W = 8;   // RING_SEC up to 255
  localparam int unsigned SNZ_CNT_W  = 10;  // 60 * 9 = 540 ticks max

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } alm_state_e;

  typedef struct packed {
    logic [3:0] hrh;
    logic [3:0] hrl;
    logic [3:0] minh;
    logic [3:0] minl;
  } hm_t;

  typedef struct packed {
    hm_t        hm;
    logic [3:0] sech;
    logic [3:0] secl;
  } bcd_time_t;

  localparam bcd_time_t LAST_SEC = 24'h23_59_59;

  // One step of a digit within 0..max, wrapping at both ends, no carry out
  function automatic logic [3:0] bcd_step(input logic [3:0] digit,
                                          input logic [3:0] max,
                                          input logic       up);
    if (up) return (digit >= max) ? 4'd0 : digit + 4'd1;
    else    return (digit == 4'd0) ? max : digit - 4'd1;
  endfunction

  function automatic logic [4:0] hr_to_bin(input logic [7:0] hr);
    return 5'(hr[7:4]) * 5'd10 + 5'(hr[3:0]);
  endfunction

  function automatic logic [7:0] bin_to_hr(input logic [4:0] b);
    if (b >= 5'd20)      return {4'd2, 4'(b - 5'd20)};
    else if (b >= 5'd10) return {4'd1, 4'(b - 5'd10)};
    else                 return {4'd0, 4'(b)};
  endfunction

  // Display hour for 12-hour mode: 0 -> 12, 13..23 -> 1..11, 1..12 unchanged
  function automatic logic [7:0] hr12_bcd(input logic [7:0] hr24);
    logic [4:0] b;
    b = hr_to_bin(hr24);
    if (b == 5'd0)       b = 5'd12;
    else if (b > 5'd12)  b = b - 5'd12;
    return bin_to_hr(b);
  endfunction

  // {pm, hr12_bcd}; pm follows the internal 24-hour value
  function automatic logic [8:0] to_12h(input logic [7:0] hr24);
    return {hr_to_bin(hr24) >= 5'd12, hr12_bcd(hr24)};
  endfunction

endpackage

// File: rtl/rtc_alarm_fsm.sv
// Alarm sequencer IDLE/RING/SNOOZE with ring-timeout and snooze countdowns on S_F.
// Ports: clk_i, rst_i (sync, active-high), sf_i tick, alm_en_i level,
//        alm_stop_i / alm_snooze_i pulses, match_i time==alarm pulse; ring_o registered.
module rtc_alarm_fsm
  import rtc_pkg::*;
#(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sf_i,
  input  logic alm_en_i,
  input  logic alm_stop_i,
  input  logic alm_snooze_i,
  input  logic match_i,
  output logic ring_o
);

  localparam logic [RING_CNT_W-1:0] RING_LOAD = RING_CNT_W'(RING_SEC);
  localparam logic [SNZ_CNT_W-1:0]  SNZ_LOAD  = SNZ_CNT_W'(60 * SNOOZE_MIN);

  alm_state_e            state_q, state_d;
  logic [RING_CNT_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [SNZ_CNT_W-1:0]  snz_cnt_q, snz_cnt_d;
  logic                  ring_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      ring_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      ring_q     <= (state_d == ST_RING);
    end
  end

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;

    if (!alm_en_i) begin
      // Disarming aborts any ring or snooze
      state_d    = ST_IDLE;
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (match_i) begin
            state_d    = ST_RING;
            ring_cnt_d = RING_LOAD;
          end
        end
        ST_RING: begin
          // Stop beats snooze when both arrive together
          if (alm_stop_i) begin
            state_d    = ST_IDLE;
            ring_cnt_d = '0;
          end else if (alm_snooze_i) begin
            state_d    = ST_SNOOZE;
            ring_cnt_d = '0;
            snz_cnt_d  = SNZ_LOAD;
          end else if (sf_i) begin
            // Counts every S_F, even while the time is paused
            if (ring_cnt_q <= RING_CNT_W'(1)) begin
              state_d    = ST_IDLE;
              ring_cnt_d = '0;
            end else begin
              ring_cnt_d = ring_cnt_q - RING_CNT_W'(1);
            end
          end
        end
        ST_SNOOZE: begin
          if (alm_stop_i) begin
            state_d   = ST_IDLE;
            snz_cnt_d = '0;
          end else if (sf_i) begin
            if (snz_cnt_q <= SNZ_CNT_W'(1)) begin
              state_d    = ST_RING;
              snz_cnt_d  = '0;
              ring_cnt_d = RING_LOAD;
            end else begin
              snz_cnt_d = snz_cnt_q - SNZ_CNT_W'(1);
            end
          end
        end
        default: begin
          state_d    = ST_IDLE;
          ring_cnt_d = '0;
          snz_cnt_d  = '0;
        end
      endcase
    end
  end

  assign ring_o = ring_q;

endmodule

// File: rtl/rtc_bcd_core.sv
// Time-of-day in 24-hour BCD with per-digit adjust, pause, 12/24h display and hh:mm alarm.
// Inputs: SYS_CLK, SYS_RST (sync, active-high), S_F tick, RUN, MODE_12H, ADJ_* adjust, ALM_* alarm.
// Outputs (registered, 1 cycle after the causing input): TIME_BCD, ALM_BCD, PM, DAY_F, ALM_RING.
module rtc_bcd_core
  import rtc_pkg::*;
#(
  parameter logic [23:0] INIT_TIME  = 24'h00_00_00,
  parameter logic [15:0] INIT_ALARM = 16'h07_00,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic        SYS_CLK,
  input  logic        SYS_RST,
  input  logic        S_F,
  input  logic        RUN,
  input  logic        MODE_12H,
  input  logic        ADJ_TARGET,
  input  logic [5:0]  ADJ_SEL,
  input  logic        ADJ_UP,
  input  logic        ADJ_DOWN,
  input  logic        ALM_EN,
  input  logic        ALM_STOP,
  input  logic        ALM_SNOOZE,
  output logic [23:0] TIME_BCD,
  output logic [23:0] ALM_BCD,
  output logic        PM,
  output logic        DAY_F,
  output logic        ALM_RING
);

  // Ripple-carry increment of the whole time; 23:59:59 wraps to 00:00:00
  function automatic bcd_time_t tick_time(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.secl != UNITS_MAX) r.secl = t.secl + 4'd1;
    else begin
      r.secl = 4'd0;
      if (t.sech != MS_TENS_MAX) r.sech = t.sech + 4'd1;
      else begin
        r.sech = 4'd0;
        if (t.hm.minl != UNITS_MAX) r.hm.minl = t.hm.minl + 4'd1;
        else begin
          r.hm.minl = 4'd0;
          if (t.hm.minh != MS_TENS_MAX) r.hm.minh = t.hm.minh + 4'd1;
          else begin
            r.hm.minh = 4'd0;
            if (t.hm.hrh == HR_TENS_MAX && t.hm.hrl == HR_UNITS_MAX2) begin
              r.hm.hrh = 4'd0;
              r.hm.hrl = 4'd0;
            end else if (t.hm.hrl == UNITS_MAX) begin
              r.hm.hrl = 4'd0;
              r.hm.hrh = t.hm.hrh + 4'd1;
            end else begin
              r.hm.hrl = t.hm.hrl + 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  // Adjust of a minute or hour digit (idx 2..5). In 12-hour mode either hour
  // digit moves the whole hour, since single digits are meaningless there.
  function automatic hm_t adjust_hm(input hm_t t, input logic [2:0] idx,
                                    input logic up, input logic m12);
    hm_t        r;
    logic [4:0] hb;
    r  = t;
    hb = hr_to_bin({t.hrh, t.hrl});
    case (idx)
      3'd2: r.minl = bcd_step(t.minl, UNITS_MAX, up);
      3'd3: r.minh = bcd_step(t.minh, MS_TENS_MAX, up);
      3'd4, 3'd5: begin
        if (m12) begin
          if (up) hb = (hb >= HR_BIN_MAX) ? 5'd0 : hb + 5'd1;
          else    hb = (hb == 5'd0) ? HR_BIN_MAX : hb - 5'd1;
          {r.hrh, r.hrl} = bin_to_hr(hb);
        end else if (idx == 3'd4) begin
          r.hrl = bcd_step(t.hrl, (t.hrh == HR_TENS_MAX) ? HR_UNITS_MAX2 : UNITS_MAX, up);
        end else begin
          r.hrh = bcd_step(t.hrh, HR_TENS_MAX, up);
          // Keep the hour legal when entering the 20s
          if (r.hrh == HR_TENS_MAX && t.hrl > HR_UNITS_MAX2) r.hrl = HR_UNITS_MAX2;
        end
      end
      default: r = t;
    endcase
    return r;
  endfunction

  bcd_time_t   time_q, time_d, time_inc, time_adj, time_nxt;
  hm_t         alm_q, alm_d, alm_adj, alm_nxt;
  logic        tick_pend_q, tick_pend_d;
  logic        day_q, day_d;
  logic [23:0] time_out_q, time_out_d;
  logic [23:0] alm_out_q, alm_out_d;
  logic        pm_q, pm_d;
  logic [8:0]  tconv;

  logic [2:0]  sel_cnt, adj_idx;
  logic        adj_ok, time_adj_vld, alm_adj_vld;
  logic        tick_acc, tick_go, match;

  // Decode the one-cold digit pointer
  always_comb begin
    sel_cnt = 3'd0;
    adj_idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (!ADJ_SEL[i]) begin
        sel_cnt = sel_cnt + 3'd1;
        adj_idx = 3'(i);
      end
    end
  end

  always_comb begin
    adj_ok       = (sel_cnt == 3'd1) && (ADJ_UP ^ ADJ_DOWN);
    time_adj_vld = adj_ok && !ADJ_TARGET;
    alm_adj_vld  = adj_ok && ADJ_TARGET && (adj_idx >= 3'd2);  // alarm has no seconds

    time_adj = time_q;
    case (adj_idx)
      3'd0:    time_adj.secl = bcd_step(time_q.secl, UNITS_MAX, ADJ_UP);
      3'd1:    time_adj.sech = bcd_step(time_q.sech, MS_TENS_MAX, ADJ_UP);
      default: time_adj.hm   = adjust_hm(time_q.hm, adj_idx, ADJ_UP, MODE_12H);
    endcase
    alm_adj = adjust_hm(alm_q, adj_idx, ADJ_UP, MODE_12H);

    // A paused clock drops S_F; a tick colliding with a time adjust is
    // deferred by one cycle, and only one such tick is ever held.
    tick_acc = S_F && RUN;
    tick_go  = !time_adj_vld && (tick_acc || tick_pend_q);
    time_inc = tick_time(time_q);

    if (time_adj_vld) begin
      time_d      = time_adj;
      tick_pend_d = tick_pend_q || tick_acc;
    end else if (tick_go) begin
      time_d      = time_inc;
      tick_pend_d = tick_pend_q && tick_acc;
    end else begin
      time_d      = time_q;
      tick_pend_d = tick_pend_q;
    end

    alm_d = alm_adj_vld ? alm_adj : alm_q;
    day_d = tick_go && (time_q == LAST_SEC);
    // Only a tick can trigger the alarm; setting the time onto it cannot
    match = tick_go && (time_inc == bcd_time_t'({alm_q, 8'h00}));
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      time_q      <= bcd_time_t'(INIT_TIME);
      alm_q       <= hm_t'(INIT_ALARM);
      tick_pend_q <= 1'b0;
      day_q       <= 1'b0;
    end else begin
      time_q      <= time_d;
      alm_q       <= alm_d;
      tick_pend_q <= tick_pend_d;
      day_q       <= day_d;
    end
  end

  // Display registers follow the next state so the outputs move with the
  // time registers; during reset they load the converted INIT values.
  always_comb begin
    time_nxt   = SYS_RST ? bcd_time_t'(INIT_TIME) : time_d;
    alm_nxt    = SYS_RST ? hm_t'(INIT_ALARM) : alm_d;
    tconv      = to_12h({time_nxt.hm.hrh, time_nxt.hm.hrl});
    time_out_d = MODE_12H ? {tconv[7:0], time_nxt[15:0]} : time_nxt;
    alm_out_d  = {MODE_12H ? hr12_bcd(alm_nxt[15:8]) : alm_nxt[15:8], alm_nxt[7:0], 8'h00};
    pm_d       = tconv[8];
  end

  always_ff @(posedge SYS_CLK) begin
    time_out_q <= time_out_d;
    alm_out_q  <= alm_out_d;
    pm_q       <= pm_d;
  end

  rtc_alarm_fsm #(
    .RING_SEC  (RING_SEC),
    .SNOOZE_MIN(SNOOZE_MIN)
  ) u_alarm (
    .clk_i       (SYS_CLK),
    .rst_i       (SYS_RST),
    .sf_i        (S_F),
    .alm_en_i    (ALM_EN),
    .alm_stop_i  (ALM_STOP),
    .alm_snooze_i(ALM_SNOOZE),
    .match_i     (match),
    .ring_o      (ALM_RING)
  );

  assign TIME_BCD = time_out_q;
  assign ALM_BCD  = alm_out_q;
  assign PM       = pm_q;
  assign DAY_F    = day_q;

endmodule

// File: tb/tb_rtc_bcd_core.sv
// Randomized and directed stimulus for rtc_bcd_core against a seconds-of-day reference model.
// Inputs change right after each falling edge; outputs are compared at the next falling edge.
// No backpressure; every cycle is checked.
module tb_rtc_bcd_core;

  localparam int RING_N  = 3;
  localparam int SNOOZE_N = 5;
  localparam int DAY_SEC = 86400;

  logic        SYS_CLK, SYS_RST, S_F, RUN, MODE_12H, ADJ_TARGET;
  logic [5:0]  ADJ_SEL;
  logic        ADJ_UP, ADJ_DOWN, ALM_EN, ALM_STOP, ALM_SNOOZE;
  logic [23:0] TIME_BCD, ALM_BCD;
  logic        PM, DAY_F, ALM_RING;

  rtc_bcd_core #(
    .INIT_TIME (24'h23_59_58),
    .INIT_ALARM(16'h07_00),
    .RING_SEC  (RING_N),
    .SNOOZE_MIN(SNOOZE_N)
  ) dut (
    .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .S_F(S_F), .RUN(RUN), .MODE_12H(MODE_12H),
    .ADJ_TARGET(ADJ_TARGET), .ADJ_SEL(ADJ_SEL), .ADJ_UP(ADJ_UP), .ADJ_DOWN(ADJ_DOWN),
    .ALM_EN(ALM_EN), .ALM_STOP(ALM_STOP), .ALM_SNOOZE(ALM_SNOOZE),
    .TIME_BCD(TIME_BCD), .ALM_BCD(ALM_BCD), .PM(PM), .DAY_F(DAY_F), .ALM_RING(ALM_RING)
  );

  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: time as seconds of day, alarm as minutes of day
  int m_tod, m_alm, m_st, m_rc, m_sc;
  bit m_pend, m_day;

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int wrap(input int d, input int max, input bit up);
    if (up) return (d == max) ? 0 : d + 1;
    return (d == 0) ? max : d - 1;
  endfunction

  function automatic int adj_sod(input int sod, input int idx, input bit up, input bit m12);
    int h, m, s, t, u;
    h = sod / 3600; m = (sod / 60) % 60; s = sod % 60;
    case (idx)
      0: s = (s / 10) * 10 + wrap(s % 10, 9, up);
      1: s = wrap(s / 10, 5, up) * 10 + s % 10;
      2: m = (m / 10) * 10 + wrap(m % 10, 9, up);
      3: m = wrap(m / 10, 5, up) * 10 + m % 10;
      4, 5: begin
        if (m12) h = (h + (up ? 1 : 23)) % 24;
        else if (idx == 4) h = (h / 10) * 10 + wrap(h % 10, (h / 10 == 2) ? 3 : 9, up);
        else begin
          t = wrap(h / 10, 2, up); u = h % 10;
          if (t == 2 && u > 3) u = 3;
          h = t * 10 + u;
        end
      end
      default: ;
    endcase
    return h * 3600 + m * 60 + s;
  endfunction

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int disp_hr(input int h, input bit m12);
    if (!m12) return h;
    if (h == 0) return 12;
    if (h > 12) return h - 12;
    return h;
  endfunction

  function automatic int digit_of(input int sod, input int d);
    int h, m, s;
    h = sod / 3600; m = (sod / 60) % 60; s = sod % 60;
    case (d)
      0: return s % 10;
      1: return s / 10;
      2: return m % 10;
      3: return m / 10;
      4: return h % 10;
      default: return h / 10;
    endcase
  endfunction

  task automatic model_reset();
    m_tod = 23 * 3600 + 59 * 60 + 58;
    m_alm = 7 * 60;
    m_st = 0; m_rc = 0; m_sc = 0;
    m_pend = 0; m_day = 0;
  endtask

  // Advance the reference by one clock using the inputs currently driven
  task automatic model_update();
    int zeros, idx;
    bit ok, tick, match;
    zeros = 0; idx = 0;
    for (int i = 0; i < 6; i++) if (ADJ_SEL[i] == 1'b0) begin zeros++; idx = i; end
    ok = (zeros == 1) && (ADJ_UP != ADJ_DOWN);
    tick = S_F && RUN;
    match = 0; m_day = 0;
    if (ok && !ADJ_TARGET) begin
      m_tod = adj_sod(m_tod, idx, ADJ_UP, MODE_12H);
      if (tick) m_pend = 1;
    end else if (tick || m_pend) begin
      m_day  = (m_tod == DAY_SEC - 1);
      m_tod  = (m_tod + 1) % DAY_SEC;
      match  = (m_tod == m_alm * 60);
      m_pend = m_pend && tick;
    end
    if (ok && ADJ_TARGET && idx >= 2) m_alm = adj_sod(m_alm * 60, idx, ADJ_UP, MODE_12H) / 60;

    if (!ALM_EN) begin
      m_st = 0;
    end else if (m_st == 0) begin
      if (match) begin m_st = 1; m_rc = RING_N; end
    end else if (m_st == 1) begin
      if (ALM_STOP) m_st = 0;
      else if (ALM_SNOOZE) begin m_st = 2; m_sc = 60 * SNOOZE_N; end
      else if (S_F) begin m_rc--; if (m_rc == 0) m_st = 0; end
    end else begin
      if (ALM_STOP) m_st = 0;
      else if (S_F) begin m_sc--; if (m_sc == 0) begin m_st = 1; m_rc = RING_N; end end
    end
  endtask

  // One clock: update reference, wait for outputs, compare, release pulses
  task automatic step();
    int h;
    model_update();
    @(negedge SYS_CLK);
    h = m_tod / 3600;
    chk("time_bcd", TIME_BCD, {bcd2(disp_hr(h, MODE_12H)), bcd2((m_tod / 60) % 60), bcd2(m_tod % 60)});
    chk("alm_bcd", ALM_BCD, {bcd2(disp_hr(m_alm / 60, MODE_12H)), bcd2(m_alm % 60), 8'h00});
    chk("pm", 24'(PM), 24'(h >= 12));
    chk("day_f", 24'(DAY_F), 24'(m_day));
    chk("alm_ring", 24'(ALM_RING), 24'(m_st == 1));
    S_F = 0; ADJ_UP = 0; ADJ_DOWN = 0; ALM_STOP = 0; ALM_SNOOZE = 0; ADJ_SEL = 6'h3f;
  endtask

  task automatic do_reset();
    SYS_RST = 1;
    repeat (3) @(negedge SYS_CLK);
    SYS_RST = 0;
    model_reset();
  endtask

  // Walk each time digit up to the target in 24-hour mode, hour tens first
  task automatic set_time(input int h, input int m, input int s);
    int tgt[6];
    logic save;
    save = MODE_12H; MODE_12H = 0; ADJ_TARGET = 0;
    tgt = '{s % 10, s / 10, m % 10, m / 10, h % 10, h / 10};
    for (int d = 5; d >= 0; d--) begin
      for (int k = 0; k < 10; k++) begin
        if (digit_of(m_tod, d) != tgt[d]) begin
          ADJ_SEL = ~(6'b000001 << d);
          ADJ_UP = 1;
          step();
        end
      end
    end
    MODE_12H = save;
  endtask

  initial begin
    bit last_sf;
    int r;
    S_F = 0; RUN = 1; MODE_12H = 0; ADJ_TARGET = 0; ADJ_SEL = 6'h3f;
    ADJ_UP = 0; ADJ_DOWN = 0; ALM_EN = 0; ALM_STOP = 0; ALM_SNOOZE = 0;
    SYS_RST = 1;
    @(negedge SYS_CLK);
    do_reset();

    // Reset state and midnight rollover
    step();
    chk("rst_time", TIME_BCD, 24'h23_59_58);
    chk("rst_ring", 24'(ALM_RING), 24'h0);
    S_F = 1; step();
    chk("tick1", TIME_BCD, 24'h23_59_59);
    chk("tick1_day", 24'(DAY_F), 24'h0);
    S_F = 1; step();
    chk("tick2", TIME_BCD, 24'h00_00_00);
    chk("tick2_day", 24'(DAY_F), 24'h1);
    step();
    chk("day_pulse_end", 24'(DAY_F), 24'h0);
    RUN = 0; S_F = 1; step();
    chk("paused", TIME_BCD, 24'h00_00_00);
    step();
    chk("paused_no_pend", TIME_BCD, 24'h00_00_00);
    RUN = 1;

    // 12-hour display
    set_time(0, 30, 0);
    MODE_12H = 1; step();
    chk("h12_midnight", TIME_BCD, 24'h12_30_00);
    chk("h12_am", 24'(PM), 24'h0);
    MODE_12H = 0;
    set_time(13, 5, 0);
    MODE_12H = 1; step();
    chk("h12_pm_time", TIME_BCD, 24'h01_05_00);
    chk("h12_pm", 24'(PM), 24'h1);
    MODE_12H = 0;

    // Hour digit adjust in 24-hour mode; entering the 20s clamps hrl to 3
    set_time(19, 0, 0);
    ADJ_SEL = 6'b011111; ADJ_UP = 1; step();
    chk("hrh_up", TIME_BCD, 24'h23_00_00);
    ADJ_SEL = 6'b011111; ADJ_UP = 1; step();
    chk("hrh_wrap", TIME_BCD, 24'h03_00_00);
    set_time(19, 0, 0);
    ADJ_SEL = 6'b101111; ADJ_UP = 1; step();
    chk("hrl_wrap", TIME_BCD, 24'h10_00_00);

    // Adjust colliding with a tick; invalid adjust combinations
    set_time(10, 9, 30);
    ADJ_SEL = 6'b111011; ADJ_UP = 1; S_F = 1; step();
    chk("collide_adj", TIME_BCD, 24'h10_00_30);
    step();
    chk("collide_pend", TIME_BCD, 24'h10_00_31);
    ADJ_SEL = 6'b111011; ADJ_UP = 1; ADJ_DOWN = 1; step();
    chk("up_and_down", TIME_BCD, 24'h10_00_31);
    ADJ_SEL = 6'b110011; ADJ_UP = 1; step();
    chk("two_sel", TIME_BCD, 24'h10_00_31);

    // Alarm ring and timeout
    ALM_EN = 1;
    set_time(6, 59, 59);
    S_F = 1; step();
    chk("alarm_ring", 24'(ALM_RING), 24'h1);
    for (int i = 0; i < RING_N; i++) begin
      S_F = 1; step(); step();
    end
    chk("ring_timeout", 24'(ALM_RING), 24'h0);

    // Snooze, re-ring, then stop+snooze together
    set_time(6, 59, 59);
    S_F = 1; step();
    chk("ring_again", 24'(ALM_RING), 24'h1);
    ALM_SNOOZE = 1; step();
    chk("snoozed", 24'(ALM_RING), 24'h0);
    for (int i = 0; i < 60 * SNOOZE_N; i++) begin
      if (i == 60 * SNOOZE_N - 1) chk("snooze_hold", 24'(ALM_RING), 24'h0);
      S_F = 1; step(); step();
    end
    chk("snooze_expire", 24'(ALM_RING), 24'h1);
    ALM_STOP = 1; ALM_SNOOZE = 1; step();
    chk("stop_wins", 24'(ALM_RING), 24'h0);
    for (int i = 0; i <= 60 * SNOOZE_N; i++) begin
      S_F = 1; step();
    end
    chk("no_rering", 24'(ALM_RING), 24'h0);

    // Reset while ringing
    set_time(6, 59, 59);
    S_F = 1; step();
    chk("ring_pre_rst", 24'(ALM_RING), 24'h1);
    do_reset();
    step();
    chk("rst_mid_ring", 24'(ALM_RING), 24'h0);
    chk("rst_mid_time", TIME_BCD, 24'h23_59_58);

    // Randomized traffic
    last_sf = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 150) set_time(((m_alm * 60 + DAY_SEC - 2) % DAY_SEC) / 3600,
                                   (((m_alm * 60 + DAY_SEC - 2) % DAY_SEC) / 60) % 60,
                                   (m_alm * 60 + DAY_SEC - 2) % 60);
      S_F = !last_sf && ($urandom_range(0, 2) == 0);
      last_sf = S_F;
      RUN = ($urandom_range(0, 7) != 0);
      r = $urandom_range(0, 9);
      if (r < 3) begin
        ADJ_SEL = ~(6'b000001 << $urandom_range(0, 5));
        ADJ_UP = 1'($urandom_range(0, 1));
        ADJ_DOWN = !ADJ_UP;
      end else if (r == 3) begin
        ADJ_SEL = 6'($urandom);
        ADJ_UP = 1'($urandom_range(0, 1));
        ADJ_DOWN = 1'($urandom_range(0, 1));
      end
      ADJ_TARGET = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) MODE_12H = !MODE_12H;
      ALM_EN = ($urandom_range(0, 29) != 0);
      ALM_STOP = ($urandom_range(0, 59) == 0);
      ALM_SNOOZE = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
